// File: rtl/snake_motion_controller_if.sv
// Button/vSync inputs and snake coordinate outputs between the VGA frame logic and the snake controller.
// master drives buttons and vSync; slave is the controller that drives coordinates and blackout.
interface snake_motion_controller_if;
  logic       vSync;
  logic       start;
  logic       btnU;
  logic       btnD;
  logic       btnL;
  logic       btnR;
  logic [9:0] xCoord1;
  logic [9:0] yCoord1;
  logic [9:0] xCoord2;
  logic [9:0] yCoord2;
  logic [9:0] xCoord3;
  logic [9:0] yCoord3;
  logic [9:0] xCoord4;
  logic [9:0] yCoord4;
  logic       blackout;

  modport master (
    output vSync, start, btnU, btnD, btnL, btnR,
    input  xCoord1, yCoord1, xCoord2, yCoord2, xCoord3, yCoord3, xCoord4, yCoord4, blackout
  );

  modport slave (
    input  vSync, start, btnU, btnD, btnL, btnR,
    output xCoord1, yCoord1, xCoord2, yCoord2, xCoord3, yCoord3, xCoord4, yCoord4, blackout
  );
endinterface

// File: rtl/snake_motion_controller.sv
// Four-segment snake sequencer: one 10-pixel grid step per FRAMES_PER_STEP frame ticks,
// with start/pause, direction latching, edge wrap or wall death followed by a blink sequence.
module snake_motion_controller #(
  parameter int FRAMES_PER_STEP = 6,
  parameter int WRAP            = 1,
  parameter int BLINK_FRAMES    = 15,
  parameter int DEAD_BLINKS     = 6
) (
  input  logic                     clk,
  input  logic                     resetn,
  snake_motion_controller_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DEAD} state_t;
  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  localparam logic [9:0] X_MAX       = 10'd635;
  localparam logic [9:0] Y_MAX       = 10'd475;
  localparam logic [9:0] G_MIN       = 10'd5;
  localparam logic [9:0] STEP        = 10'd10;
  localparam logic [5:0] STEP_LAST   = 6'(FRAMES_PER_STEP - 1);
  localparam logic [5:0] BLINK_LAST  = 6'(BLINK_FRAMES - 1);
  localparam logic [5:0] TOGGLE_LAST = 6'(DEAD_BLINKS - 1);
  localparam logic [9:0] HOME_X [4]  = '{10'd325, 10'd315, 10'd305, 10'd295};
  localparam logic [9:0] HOME_Y [4]  = '{10'd245, 10'd245, 10'd245, 10'd245};

  state_t     state_q;
  dir_t       cur_dir_q;
  dir_t       pend_dir_q;
  dir_t       pend_dir_d;
  dir_t       req_dir;
  dir_t       opp_dir;
  logic       req_vld;
  logic [5:0] step_cnt_q;
  logic [5:0] blink_cnt_q;
  logic [5:0] toggle_cnt_q;
  logic       vsync_q;
  logic       start_q;
  logic       blackout_q;
  logic [9:0] x_q [4];
  logic [9:0] y_q [4];
  logic [9:0] head_x_d;
  logic [9:0] head_y_d;
  logic       edge_hit;
  logic       tick;
  logic       press;

  assign tick  = vsync_q & ~bus.vSync;
  assign press = bus.start & ~start_q;

  // A request reversing the applied direction would fold the snake onto itself.
  always_comb begin
    opp_dir = dir_t'(cur_dir_q ^ 2'b01);
    req_vld = bus.btnU | bus.btnD | bus.btnL | bus.btnR;
    if (bus.btnU)      req_dir = D_UP;
    else if (bus.btnD) req_dir = D_DOWN;
    else if (bus.btnL) req_dir = D_LEFT;
    else               req_dir = D_RIGHT;
    pend_dir_d = (req_vld && (req_dir != opp_dir)) ? req_dir : pend_dir_q;
  end

  always_comb begin
    head_x_d = x_q[0];
    head_y_d = y_q[0];
    edge_hit = 1'b0;
    case (pend_dir_q)
      D_UP: begin
        edge_hit = (y_q[0] == G_MIN);
        head_y_d = edge_hit ? Y_MAX : y_q[0] - STEP;
      end
      D_DOWN: begin
        edge_hit = (y_q[0] == Y_MAX);
        head_y_d = edge_hit ? G_MIN : y_q[0] + STEP;
      end
      D_LEFT: begin
        edge_hit = (x_q[0] == G_MIN);
        head_x_d = edge_hit ? X_MAX : x_q[0] - STEP;
      end
      default: begin
        edge_hit = (x_q[0] == X_MAX);
        head_x_d = edge_hit ? G_MIN : x_q[0] + STEP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cur_dir_q    <= D_RIGHT;
      pend_dir_q   <= D_RIGHT;
      step_cnt_q   <= '0;
      blink_cnt_q  <= '0;
      toggle_cnt_q <= '0;
      vsync_q      <= 1'b1;
      start_q      <= 1'b0;
      blackout_q   <= 1'b0;
      x_q          <= HOME_X;
      y_q          <= HOME_Y;
    end else begin
      vsync_q <= bus.vSync;
      start_q <= bus.start;
      case (state_q)
        S_IDLE: begin
          if (press) begin
            state_q    <= S_RUN;
            step_cnt_q <= '0;
          end
        end
        S_RUN: begin
          pend_dir_q <= pend_dir_d;
          if (press) state_q <= S_PAUSE;
          if (tick) begin
            if (step_cnt_q == STEP_LAST) begin
              step_cnt_q <= '0;
              // Wall death overrides a simultaneous pause request.
              if (edge_hit && (WRAP == 0)) begin
                state_q      <= S_DEAD;
                blackout_q   <= 1'b1;
                blink_cnt_q  <= '0;
                toggle_cnt_q <= '0;
              end else begin
                cur_dir_q <= pend_dir_q;
                x_q[0]    <= head_x_d;
                y_q[0]    <= head_y_d;
                x_q[1]    <= x_q[0];
                y_q[1]    <= y_q[0];
                x_q[2]    <= x_q[1];
                y_q[2]    <= y_q[1];
                x_q[3]    <= x_q[2];
                y_q[3]    <= y_q[2];
              end
            end else begin
              step_cnt_q <= step_cnt_q + 6'd1;
            end
          end
        end
        S_PAUSE: begin
          pend_dir_q <= pend_dir_d;
          if (press) state_q <= S_RUN;
        end
        S_DEAD: begin
          if (tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_q <= '0;
              if (toggle_cnt_q == TOGGLE_LAST) begin
                state_q      <= S_IDLE;
                toggle_cnt_q <= '0;
                blackout_q   <= 1'b0;
                cur_dir_q    <= D_RIGHT;
                pend_dir_q   <= D_RIGHT;
                x_q          <= HOME_X;
                y_q          <= HOME_Y;
              end else begin
                toggle_cnt_q <= toggle_cnt_q + 6'd1;
                blackout_q   <= ~blackout_q;
              end
            end else begin
              blink_cnt_q <= blink_cnt_q + 6'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.xCoord1  = x_q[0];
  assign bus.yCoord1  = y_q[0];
  assign bus.xCoord2  = x_q[1];
  assign bus.yCoord2  = y_q[1];
  assign bus.xCoord3  = x_q[2];
  assign bus.yCoord3  = y_q[2];
  assign bus.xCoord4  = x_q[3];
  assign bus.yCoord4  = y_q[3];
  assign bus.blackout = blackout_q;

endmodule
